axi_aw_qos_allocator: RTL

//  Next-generation AW channel allocator: arbitrates AW requests from N_TARG_PORT slave ports onto one master port.

---
 rtl/axi_node_pkg.sv | 29 ++
 rtl/axi_aw_id_fifo.sv | 57 +++++
 rtl/axi_aw_qos_allocator.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_node_pkg.sv
// Shared AXI node types and helpers: QoS width, aged-priority value,
// AW hold-state encoding and a one-hot to binary converter.
package axi_node_pkg;

  localparam int unsigned QOS_W    = 4;
  localparam logic [3:0]  QOS_AGED = 4'hF;

  // Widest one-hot vector onehot2bin accepts, and its binary width
  localparam int unsigned OH_MAX_W = 64;
  localparam int unsigned OH_BIN_W = 6;

  typedef enum logic {
    AW_IDLE = 1'b0,
    AW_HOLD = 1'b1
  } aw_state_e;

  function automatic logic [OH_BIN_W-1:0] onehot2bin(input logic [OH_MAX_W-1:0] oh);
    logic [OH_BIN_W-1:0] bin;
    logic [OH_MAX_W-1:0] v;
    bin = '0;
    v   = oh;
    for (int unsigned i = 0; i < OH_MAX_W; i++) begin
      if (v[0]) bin = bin | OH_BIN_W'(i);
      v = v >> 1;
    end
    return bin;
  endfunction

endpackage

// File: rtl/axi_aw_id_fifo.sv
// W-routing ID FIFO: holds {binary, one-hot} port index of each accepted
// AW burst until the W allocator consumes it. Pop on empty is ignored.
module axi_aw_id_fifo #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) pop_i |-> !empty_o);

endmodule

// File: rtl/axi_aw_qos_allocator.sv
// AW channel allocator: picks the highest-QoS valid slave port (round-robin
// on ties), holds the winner until the master accepts it, and records the
// winner in an embedded ID FIFO for W routing.
// Optional build macro AXI_AW_QOS_AGING_EN adds per-port starvation aging.
module axi_aw_qos_allocator
  import axi_node_pkg::*;
#(
  parameter int unsigned AXI_ADDRESS_W = 32,
  parameter int unsigned AXI_USER_W    = 6,
  parameter int unsigned N_TARG_PORT   = 7,
  parameter int unsigned LOG_N_TARG    = $clog2(N_TARG_PORT),
  parameter int unsigned AXI_ID_IN     = 16,
  parameter int unsigned AXI_ID_OUT    = AXI_ID_IN + LOG_N_TARG,
  parameter int unsigned ID_FIFO_DEPTH = 8,
  parameter int unsigned AGE_THRESHOLD = 16
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [N_TARG_PORT-1:0][AXI_ID_IN-1:0]      awid_i,
  input  logic [N_TARG_PORT-1:0][AXI_ADDRESS_W-1:0]  awaddr_i,
  input  logic [N_TARG_PORT-1:0][7:0]                awlen_i,
  input  logic [N_TARG_PORT-1:0][2:0]                awsize_i,
  input  logic [N_TARG_PORT-1:0][1:0]                awburst_i,
  input  logic [N_TARG_PORT-1:0]                     awlock_i,
  input  logic [N_TARG_PORT-1:0][3:0]                awcache_i,
  input  logic [N_TARG_PORT-1:0][2:0]                awprot_i,
  input  logic [N_TARG_PORT-1:0][3:0]                awregion_i,
  input  logic [N_TARG_PORT-1:0][AXI_USER_W-1:0]     awuser_i,
  input  logic [N_TARG_PORT-1:0][QOS_W-1:0]          awqos_i,
  input  logic [N_TARG_PORT-1:0]                     awvalid_i,
  output logic [N_TARG_PORT-1:0]                     awready_o,
  output logic [AXI_ID_OUT-1:0]                      awid_o,
  output logic [AXI_ADDRESS_W-1:0]                   awaddr_o,
  output logic [7:0]                                 awlen_o,
  output logic [2:0]                                 awsize_o,
  output logic [1:0]                                 awburst_o,
  output logic                                       awlock_o,
  output logic [3:0]                                 awcache_o,
  output logic [2:0]                                 awprot_o,
  output logic [3:0]                                 awregion_o,
  output logic [AXI_USER_W-1:0]                      awuser_o,
  output logic [QOS_W-1:0]                           awqos_o,
  output logic                                       awvalid_o,
  input  logic                                       awready_i,
  output logic [LOG_N_TARG+N_TARG_PORT-1:0]          ID_o,
  output logic                                       id_valid_o,
  input  logic                                       pop_ID_i
);

  if (N_TARG_PORT < 2 || N_TARG_PORT > OH_MAX_W) begin : g_bad_ports
    $error("N_TARG_PORT out of range");
  end
  if (ID_FIFO_DEPTH < 2 || (ID_FIFO_DEPTH & (ID_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ID_FIFO_DEPTH must be a power of two >= 2");
  end
  if (AGE_THRESHOLD < 1) begin : g_bad_age
    $error("AGE_THRESHOLD must be >= 1");
  end

  localparam int unsigned IDX_W  = LOG_N_TARG + 1;
  localparam int unsigned FIFO_W = LOG_N_TARG + N_TARG_PORT;

  typedef struct packed {
    logic [AXI_ID_IN-1:0]     id;
    logic [AXI_ADDRESS_W-1:0] addr;
    logic [7:0]               len;
    logic [2:0]               size;
    logic [1:0]               burst;
    logic                     lock;
    logic [3:0]               cache;
    logic [2:0]               prot;
    logic [3:0]               region;
    logic [AXI_USER_W-1:0]    user;
    logic [QOS_W-1:0]         qos;
  } aw_payload_t;

  aw_payload_t [N_TARG_PORT-1:0]    port_pl;
  aw_payload_t                      win_pl;
  logic [N_TARG_PORT-1:0][QOS_W:0]  prio;
  logic [N_TARG_PORT-1:0]           aged;
  logic [N_TARG_PORT-1:0]           arb_oh;
  logic [N_TARG_PORT-1:0]           sel_oh;
  logic [LOG_N_TARG-1:0]            arb_sel;
  logic [LOG_N_TARG-1:0]            sel;
  logic [LOG_N_TARG-1:0]            sel_q;
  logic [LOG_N_TARG-1:0]            rr_q;
  logic [LOG_N_TARG-1:0]            idx;
  logic [IDX_W-1:0]                 idx_w;
  logic [QOS_W:0]                   best;
  logic                             found;
  logic                             hold_q;
  logic                             hs;
  logic                             fifo_full;
  logic                             fifo_empty;
  aw_state_e                        state_q;
  aw_state_e                        state_d;

  // Priority key is {aged, eff_qos}: the aged bit outranks any plain QoS tie
  for (genvar p = 0; p < N_TARG_PORT; p++) begin : g_port
    assign port_pl[p] = '{id: awid_i[p], addr: awaddr_i[p], len: awlen_i[p],
                          size: awsize_i[p], burst: awburst_i[p], lock: awlock_i[p],
                          cache: awcache_i[p], prot: awprot_i[p], region: awregion_i[p],
                          user: awuser_i[p], qos: awqos_i[p]};
    assign prio[p] = aged[p] ? {1'b1, QOS_AGED} : {1'b0, awqos_i[p]};
  end

`ifdef AXI_AW_QOS_AGING_EN
  localparam int unsigned AGE_W = $clog2(AGE_THRESHOLD + 1);
  for (genvar p = 0; p < N_TARG_PORT; p++) begin : g_age
    logic [AGE_W-1:0] age_q;
    // Saturating wait counter: cleared on own handshake or dropped request
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        age_q <= '0;
      end else if (!awvalid_i[p] || awready_o[p]) begin
        age_q <= '0;
      end else if (age_q < AGE_W'(AGE_THRESHOLD)) begin
        age_q <= age_q + AGE_W'(1);
      end
    end
    assign aged[p] = (age_q >= AGE_W'(AGE_THRESHOLD));
  end
`else
  assign aged = '0;
`endif

  // Scan ports starting at rr_q; strictly-greater keeps the earliest on a tie
  always_comb begin
    arb_oh = '0;
    best   = '0;
    found  = 1'b0;
    idx_w  = '0;
    idx    = '0;
    for (int unsigned k = 0; k < N_TARG_PORT; k++) begin
      idx_w = {1'b0, rr_q} + IDX_W'(k);
      if (idx_w >= IDX_W'(N_TARG_PORT)) idx_w = idx_w - IDX_W'(N_TARG_PORT);
      idx = idx_w[LOG_N_TARG-1:0];
      if (awvalid_i[idx] && (!found || prio[idx] > best)) begin
        found       = 1'b1;
        best        = prio[idx];
        arb_oh      = '0;
        arb_oh[idx] = 1'b1;
      end
    end
  end

  assign arb_sel = LOG_N_TARG'(onehot2bin(OH_MAX_W'(arb_oh)));
  assign hold_q  = (state_q == AW_HOLD);
  assign sel     = hold_q ? sel_q : arb_sel;
  assign sel_oh  = hold_q ? (N_TARG_PORT'(1) << sel_q) : arb_oh;
  assign win_pl  = port_pl[sel];

  // A pending grant always has a FIFO slot reserved, so full never blocks a hold
  assign awvalid_o = rst_n & ~fifo_full & (hold_q | (|awvalid_i));
  assign hs        = awvalid_o & awready_i;
  assign awready_o = hs ? sel_oh : '0;

  assign awid_o     = {sel, win_pl.id};
  assign awaddr_o   = win_pl.addr;
  assign awlen_o    = win_pl.len;
  assign awsize_o   = win_pl.size;
  assign awburst_o  = win_pl.burst;
  assign awlock_o   = win_pl.lock;
  assign awcache_o  = win_pl.cache;
  assign awprot_o   = win_pl.prot;
  assign awregion_o = win_pl.region;
  assign awuser_o   = win_pl.user;
  assign awqos_o    = win_pl.qos;

  // Hold FSM: stalled offer locks the selection until accepted
  always_comb begin
    state_d = state_q;
    case (state_q)
      AW_IDLE: if (awvalid_o && !awready_i) state_d = AW_HOLD;
      AW_HOLD: if (hs) state_d = AW_IDLE;
      default: state_d = AW_IDLE;
    endcase
  end

  // State, held selection and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= AW_IDLE;
      sel_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      if (awvalid_o && !awready_i) sel_q <= sel;
      if (hs) rr_q <= (sel == LOG_N_TARG'(N_TARG_PORT - 1)) ? '0 : sel + LOG_N_TARG'(1);
    end
  end

  axi_aw_id_fifo #(
    .DATA_W (FIFO_W),
    .DEPTH  (ID_FIFO_DEPTH)
  ) u_id_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (hs),
    .data_i  ({sel, sel_oh}),
    .pop_i   (pop_ID_i),
    .data_o  (ID_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign id_valid_o = ~fifo_empty;

  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n) hold_q |-> awvalid_i[sel_q]);

endmodule
